// File: rtl/uart_rx_if.sv
// Bus bundle for uart_rx: register-write config port plus the received-byte/error outputs.
// The receiver connects to the slave modport and the consumer/config master to the master modport.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 c_valid;
  logic [3:0]           c_addr;
  logic [7:0]           c_data;
  logic                 c_ready;
  logic [DATA_BITS-1:0] out;
  logic                 valid_out;
  logic [1:0]           error;
  logic                 valid_error;

  modport master (
    output c_valid, c_addr, c_data,
    input  c_ready, out, valid_out, error, valid_error
  );

  modport slave (
    input  c_valid, c_addr, c_data,
    output c_ready, out, valid_out, error, valid_error
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with programmable stop bits and framing/parity error reporting.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in,
  uart_rx_if.slave bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic [TickW-1:0]     tick_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;
  logic                 stop2_q;
  logic [DATA_BITS-1:0] out_q;
  logic                 valid_out_q;
  logic [1:0]           error_q;
  logic                 valid_error_q;
  logic                 rx;
  logic                 c_ready;
  logic                 unused_cfg;
`ifdef UART_RX_PARITY_EN
  logic [1:0]           parity_mode_q;
  logic                 par_err_q;
  logic                 parity_on;

  assign parity_on = ^parity_mode_q;
`endif

  assign rx         = sync_q[1];
  assign c_ready    = (state_q == StIdle);
  assign unused_cfg = ^bus.c_data[7:1];

  assign bus.c_ready     = c_ready;
  assign bus.out         = out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.error       = error_q;
  assign bus.valid_error = valid_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sync_q        <= 2'b11;
      rx_prev_q     <= 1'b1;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      stop2_q       <= 1'b0;
      out_q         <= '0;
      valid_out_q   <= 1'b0;
      error_q       <= 2'b00;
      valid_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_mode_q <= 2'b00;
      par_err_q     <= 1'b0;
`endif
    end else begin
      sync_q        <= {sync_q[0], in};
      rx_prev_q     <= rx;
      valid_out_q   <= 1'b0;
      valid_error_q <= 1'b0;

      // c_ready is only high in IDLE, so config is frozen for the whole frame.
      if (bus.c_valid && c_ready) begin
        case (bus.c_addr)
`ifdef UART_RX_PARITY_EN
          4'h5:    parity_mode_q <= bus.c_data[1:0];
`endif
          4'h6:    stop2_q <= bus.c_data[0];
          default: ;
        endcase
      end

      if (state_q != StIdle) tick_q <= tick_q + TickW'(1);

      case (state_q)
        StIdle: begin
          tick_q <= '0;
          bit_q  <= '0;
          if (rx_prev_q && !rx) state_q <= StStart;
        end
        StStart: begin
          if (tick_q == TickMid) begin
            tick_q      <= '0;
            bit_q       <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            state_q     <= rx ? StIdle : StData;
          end
        end
        StData: begin
          if (tick_q == TickEnd) begin
            tick_q  <= '0;
            shift_q <= {rx, shift_q[DATA_BITS-1:1]};
            if (bit_q == LastBit) begin
              bit_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= parity_on ? StParity : StStop;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_q <= bit_q + BitW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          // Odd mode (01) wants data^parity == 1, even mode (10) wants 0.
          if (tick_q == TickEnd) begin
            tick_q    <= '0;
            par_err_q <= ((^shift_q) ^ rx) != parity_mode_q[0];
            state_q   <= StStop;
          end
        end
`endif
        StStop: begin
          if (tick_q == TickEnd) begin
            tick_q <= '0;
            if (!rx) frame_err_q <= 1'b1;
            if (stop2_q && bit_q == '0) bit_q <= BitW'(1);
            else state_q <= StDone;
          end
        end
        StDone: begin
          out_q         <= shift_q;
          valid_out_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
          error_q       <= {par_err_q, frame_err_q};
`else
          error_q       <= {1'b0, frame_err_q};
`endif
          valid_error_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames, back-to-back traffic, glitches, framing errors,
// config gating, stop-bit/parity modes and reset mid-frame.
module tb_uart_rx;
  localparam int CLK = 74;
  localparam int BIT = 1184;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] byte_q[$];
  logic [1:0] err_q[$];

  uart_rx_if #(.DATA_BITS(8)) u_if ();

  uart_rx #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in (line),
    .bus(u_if.slave)
  );

  always #(CLK / 2) clk = ~clk;

  always @(negedge clk) begin
    if (!rst && u_if.valid_out) byte_q.push_back(u_if.out);
    if (!rst && u_if.valid_error) err_q.push_back(u_if.error);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag, input logic [7:0] b, input logic [1:0] e);
    chk({tag, "_pending"}, 32'(byte_q.size() > 0 && err_q.size() > 0), 32'd1);
    if (byte_q.size() > 0 && err_q.size() > 0) begin
      chk({tag, "_byte"}, 32'(byte_q.pop_front()), 32'(b));
      chk({tag, "_err"}, 32'(err_q.pop_front()), 32'(e));
    end
  endtask

  task automatic check_none(input string tag);
    chk({tag, "_extra_out"}, 32'(byte_q.size()), 32'd0);
    chk({tag, "_extra_err"}, 32'(err_q.size()), 32'd0);
    byte_q.delete();
    err_q.delete();
  endtask

  // Drives 16 line bits LSB first; optionally tries a stop2 write in the middle of the frame.
  task automatic send(input logic [15:0] pat, input bit cfg_mid);
    for (int i = 0; i < 16; i++) begin
      line = pat[i];
      if (cfg_mid && i == 4) begin
        #(BIT / 2);
        u_if.c_valid = 1'b1;
        u_if.c_addr  = 4'h6;
        u_if.c_data  = 8'h01;
        #(2 * CLK);
        chk("cfg_busy_ready", 32'(u_if.c_ready), 32'd0);
        u_if.c_valid = 1'b0;
        #(BIT / 2 - 2 * CLK);
      end else begin
        #(BIT);
      end
    end
  endtask

  // One stop bit high, then a short low pulse centred on where a second stop bit is sampled.
  task automatic send_gstop(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line = f[i];
      #(BIT);
    end
    line = 1'b1;
    #(5 * CLK);
    line = 1'b0;
    #(6 * CLK);
    line = 1'b1;
    #(5 * CLK + 4 * BIT);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    u_if.c_valid = 1'b1;
    u_if.c_addr  = a;
    u_if.c_data  = d;
    #1;
    chk("cfg_idle_ready", 32'(u_if.c_ready), 32'd1);
    @(negedge clk);
    u_if.c_valid = 1'b0;
  endtask

  initial begin
    u_if.c_valid = 1'b0;
    u_if.c_addr  = 4'h0;
    u_if.c_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out", 32'(u_if.out), 32'h0);
    chk("rst_valid_out", 32'(u_if.valid_out), 32'd0);
    chk("rst_error", 32'(u_if.error), 32'd0);
    chk("rst_valid_error", 32'(u_if.valid_error), 32'd0);
    chk("rst_c_ready", 32'(u_if.c_ready), 32'd1);
    #(2 * BIT);

    // Start bit is line bit 3; data bits 4..11 = 0,1,0,1,1,1,0,1 -> 8'hBA.
    send(16'hFBA7, 1'b0);
    check_rx("f1", 8'hBA, 2'b00);
    check_none("f1");

    send(16'hFEAA, 1'b0);
    send(16'hF54F, 1'b0);
    send(16'hFFFE, 1'b0);
    send(16'hFF00, 1'b0);
    send(16'hFE00, 1'b0);
    check_rx("b2b0", 8'h55, 2'b00);
    check_rx("b2b1", 8'hAA, 2'b00);
    check_rx("b2b2", 8'hFF, 2'b00);
    check_rx("b2b3", 8'h80, 2'b00);
    check_rx("b2b4", 8'h00, 2'b00);
    check_none("b2b");

    line = 1'b0;
    #(4 * CLK);
    line = 1'b1;
    #(3 * BIT);
    check_none("glitch");
    chk("glitch_idle", 32'(u_if.c_ready), 32'd1);

    send({6'h3F, 1'b0, 8'h3C, 1'b0}, 1'b0);
    check_rx("frame", 8'h3C, 2'b01);
    chk("frame_err_hold", 32'(u_if.error), 32'h1);
    send(16'hFEAA, 1'b0);
    check_rx("recover", 8'h55, 2'b00);
    check_none("frame");

    send({6'h3F, 1'b1, 8'h5A, 1'b0}, 1'b1);
    check_rx("cfg_busy", 8'h5A, 2'b00);
    send_gstop(8'hC3);
    check_rx("stop1_glitch", 8'hC3, 2'b00);
    check_none("stop1");

    cfg_write(4'h6, 8'h01);
    send_gstop(8'h81);
    check_rx("stop2_bad", 8'h81, 2'b01);
    send({5'h1F, 1'b1, 1'b1, 8'h7E, 1'b0}, 1'b0);
    check_rx("stop2_good", 8'h7E, 2'b00);
    check_none("stop2");

`ifdef UART_RX_PARITY_EN
    cfg_write(4'h5, 8'h02);
    send({5'h1F, 1'b1, 1'b1, 1'b0, 8'hB4, 1'b0}, 1'b0);
    check_rx("par_ok", 8'hB4, 2'b00);
    send({5'h1F, 1'b1, 1'b1, 1'b1, 8'hB4, 1'b0}, 1'b0);
    check_rx("par_bad", 8'hB4, 2'b10);
    check_none("par");
    cfg_write(4'h5, 8'h00);
    cfg_write(4'h6, 8'h00);
`else
    cfg_write(4'h6, 8'h00);
    cfg_write(4'h5, 8'h02);
    send({6'h3F, 1'b1, 8'hB4, 1'b0}, 1'b0);
    check_rx("nopar", 8'hB4, 2'b00);
    check_none("nopar");
`endif

    line = 1'b0;
    #(BIT);
    line = 1'b1;
    #(BIT);
    line = 1'b0;
    #(BIT);
    line = 1'b1;
    rst  = 1'b1;
    #(2 * CLK);
    rst = 1'b0;
    #(3 * BIT);
    check_none("rst_mid");
    chk("rst_mid_out", 32'(u_if.out), 32'h0);
    chk("rst_mid_error", 32'(u_if.error), 32'h0);
    chk("rst_mid_ready", 32'(u_if.c_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
